// File: rtl/sar_ctrl_param.sv
// sar_ctrl_param: NBITS-bit SAR ADC sequencer (sample -> successive approximation -> optional
// offset-calibration cycle) with a parallel result buffer and valid/ready handshake.
//
// Ports:
//   clk, rst_z               clock (one per bit decision), async active-low reset
//   start, cont              begin conversion (IDLE only); continuous re-sampling while high
//   en_offset_cal            append one calibration cycle (latched at CONVERT entry)
//   sample_len               sample window length minus 1 (latched at SAMPLE entry)
//   comp_p                   comparator decision, 1 = DAC above input
//   vin_p_sw_on, vin_n_sw_on input switches still closed; blocks VCM connection
//   data_ready               consumer accepts data_o
//   sample_o, en_comp        sampling switch enable, comparator strobe (low clock phase)
//   offset_cal_cycle         current cycle is the calibration cycle
//   vcm_o, vref_z_*_o, vss_*_o  per-capacitor DAC switches for bits NBITS-1..1
//   data_o, data_valid       last completed result and its unconsumed flag
//   overrun                  one-cycle pulse: an unconsumed result was overwritten
//   busy                     not idle
module sar_ctrl_param #(
  parameter int unsigned NBITS  = 12,
  parameter int unsigned SLEN_W = 4
) (
  input  logic              clk,
  input  logic              rst_z,
  input  logic              start,
  input  logic              cont,
  input  logic              en_offset_cal,
  input  logic [SLEN_W-1:0] sample_len,
  input  logic              comp_p,
  input  logic              vin_p_sw_on,
  input  logic              vin_n_sw_on,
  input  logic              data_ready,
  output logic              sample_o,
  output logic              en_comp,
  output logic              offset_cal_cycle,
  output logic [NBITS-2:0]  vcm_o,
  output logic [NBITS-2:0]  vref_z_p_o,
  output logic [NBITS-2:0]  vref_z_n_o,
  output logic [NBITS-2:0]  vss_p_o,
  output logic [NBITS-2:0]  vss_n_o,
  output logic [NBITS-1:0]  data_o,
  output logic              data_valid,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned CW = $clog2(NBITS + 1);

  typedef enum logic [1:0] {StIdle, StSample, StConvert} state_e;

  state_e             state_q, state_d;
  logic [SLEN_W-1:0]  slen_q, slen_d;
  logic [SLEN_W-1:0]  scnt_q, scnt_d;
  logic [CW-1:0]      bcnt_q, bcnt_d;
  logic               cal_q, cal_d;
  logic [NBITS-1:0]   result_q, result_d;
  logic [NBITS-1:0]   decided_q, decided_d;
  logic [NBITS-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;

  logic               in_conv;
  logic               conv_last;
  logic               enter_sample;
  logic               load;

  assign in_conv   = (state_q == StConvert);
  assign conv_last = in_conv && (bcnt_q == (cal_q ? CW'(NBITS) : CW'(NBITS - 1)));

  always_ff @(posedge clk or negedge rst_z) begin
    if (!rst_z) begin
      state_q   <= StIdle;
      slen_q    <= '0;
      scnt_q    <= '0;
      bcnt_q    <= '0;
      cal_q     <= 1'b0;
      result_q  <= '0;
      decided_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      slen_q    <= slen_d;
      scnt_q    <= scnt_d;
      bcnt_q    <= bcnt_d;
      cal_q     <= cal_d;
      result_q  <= result_d;
      decided_q <= decided_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    slen_d       = slen_q;
    scnt_d       = scnt_q;
    bcnt_d       = bcnt_q;
    cal_d        = cal_q;
    result_d     = result_q;
    decided_d    = decided_q;
    data_d       = data_q;
    enter_sample = 1'b0;
    load         = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) enter_sample = 1'b1;
      end
      StSample: begin
        if (scnt_q == slen_q) begin
          state_d = StConvert;
          bcnt_d  = '0;
          cal_d   = en_offset_cal;
        end else begin
          scnt_d = scnt_q + SLEN_W'(1);
        end
      end
      StConvert: begin
        // Decision cycle j writes bit NBITS-1-j; the cal cycle (j == NBITS) matches no bit.
        for (int i = 0; i < int'(NBITS); i++) begin
          if (bcnt_q == CW'(int'(NBITS) - 1 - i)) begin
            result_d[i]  = comp_p;
            decided_d[i] = 1'b1;
          end
        end
        bcnt_d = bcnt_q + CW'(1);
        if (conv_last) begin
          data_d = result_d;
          load   = 1'b1;
          if (cont) enter_sample = 1'b1;
          else      state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (enter_sample) begin
      state_d   = StSample;
      slen_d    = sample_len;
      scnt_d    = '0;
      result_d  = '0;
      decided_d = '0;
    end

    // A load on the same edge as a consume keeps the buffer full without overrun.
    ovr_d = load & valid_q & ~data_ready;
    if (load)                       valid_d = 1'b1;
    else if (valid_q && data_ready) valid_d = 1'b0;
    else                            valid_d = valid_q;
  end

  // Per-capacitor switches; VCM only while undecided, so it never overlaps VREF/VSS.
  always_comb begin
    vcm_o      = '0;
    vref_z_p_o = '1;
    vref_z_n_o = '1;
    vss_p_o    = '0;
    vss_n_o    = '0;
    for (int b = 1; b < int'(NBITS); b++) begin
      vcm_o[b-1]      = in_conv & ~decided_q[b] & ~(vin_p_sw_on | vin_n_sw_on);
      vss_p_o[b-1]    = in_conv & decided_q[b] & result_q[b];
      vref_z_n_o[b-1] = ~(in_conv & decided_q[b] & result_q[b]);
      vref_z_p_o[b-1] = ~(in_conv & decided_q[b] & ~result_q[b]);
      vss_n_o[b-1]    = in_conv & decided_q[b] & ~result_q[b];
    end
  end

  // State only changes on the rising edge, while ~clk is low, so the strobe cannot glitch.
  assign en_comp          = ~clk & in_conv;
  assign sample_o         = (state_q == StSample);
  assign offset_cal_cycle = in_conv & cal_q & (bcnt_q == CW'(NBITS));
  assign busy             = (state_q != StIdle);
  assign data_o           = data_q;
  assign data_valid       = valid_q;
  assign overrun          = ovr_q;

endmodule

// File: tb/tb_sar_ctrl_param.sv
module tb_sar_ctrl_param;

  localparam int NB = 12;
  localparam int SW = 4;

  logic          clk;
  logic          rst_z;
  logic          start;
  logic          cont;
  logic          en_offset_cal;
  logic [SW-1:0] sample_len;
  logic          comp_p;
  logic          vin_p_sw_on;
  logic          vin_n_sw_on;
  logic          data_ready;
  logic          sample_o;
  logic          en_comp;
  logic          offset_cal_cycle;
  logic [NB-2:0] vcm_o;
  logic [NB-2:0] vref_z_p_o;
  logic [NB-2:0] vref_z_n_o;
  logic [NB-2:0] vss_p_o;
  logic [NB-2:0] vss_n_o;
  logic [NB-1:0] data_o;
  logic          data_valid;
  logic          overrun;
  logic          busy;

  int checks;
  int errors;

  sar_ctrl_param #(.NBITS(NB), .SLEN_W(SW)) dut (
    .clk              (clk),
    .rst_z            (rst_z),
    .start            (start),
    .cont             (cont),
    .en_offset_cal    (en_offset_cal),
    .sample_len       (sample_len),
    .comp_p           (comp_p),
    .vin_p_sw_on      (vin_p_sw_on),
    .vin_n_sw_on      (vin_n_sw_on),
    .data_ready       (data_ready),
    .sample_o         (sample_o),
    .en_comp          (en_comp),
    .offset_cal_cycle (offset_cal_cycle),
    .vcm_o            (vcm_o),
    .vref_z_p_o       (vref_z_p_o),
    .vref_z_n_o       (vref_z_n_o),
    .vss_p_o          (vss_p_o),
    .vss_n_o          (vss_n_o),
    .data_o           (data_o),
    .data_valid       (data_valid),
    .overrun          (overrun),
    .busy             (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [NB-1:0] code;
    int            l;
    bit            cal;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Low-phase checks: comparator strobe and VCM/VREF/VSS exclusivity.
  task automatic negchk(input logic exp_en);
    @(negedge clk);
    #1;
    chk("en_comp", en_comp, exp_en);
    chk("interlock", vcm_o & (~vref_z_p_o | ~vref_z_n_o | vss_p_o | vss_n_o), 0);
  endtask

  // Reference switch pattern in CONVERT cycle j for a converter tracking 'code'.
  task automatic swchk(input logic [NB-1:0] code, input int j, input bit conv);
    logic [NB-2:0] vcm, vrp, vrn, vsp, vsn;
    bit dec, one;
    for (int b = 1; b < NB; b++) begin
      dec = conv && ((NB - 1 - b) < j);
      one = code[b];
      vcm[b-1] = conv && !dec && !(vin_p_sw_on || vin_n_sw_on);
      vsp[b-1] = dec && one;
      vrn[b-1] = !(dec && one);
      vrp[b-1] = !(dec && !one);
      vsn[b-1] = dec && !one;
    end
    chk("vcm_o", vcm_o, vcm);
    chk("vref_z_p_o", vref_z_p_o, vrp);
    chk("vref_z_n_o", vref_z_n_o, vrn);
    chk("vss_p_o", vss_p_o, vsp);
    chk("vss_n_o", vss_n_o, vsn);
  endtask

  task automatic launch(input int l);
    sample_len = SW'(l);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Drives one conversion from the first SAMPLE cycle through the final edge.
  task automatic body(input logic [NB-1:0] code, input int l, input bit cal,
                      input bit ready_last, input bit pv, input bit exp_ov, input int start_at);
    int k;
    k = NB + int'(cal);
    en_offset_cal = cal;
    data_ready    = 1'b0;
    for (int s = 0; s <= l; s++) begin
      sample_len = SW'(l ^ 5);  // must not alter the window already latched
      chk("sample_o", sample_o, 1);
      chk("busy_sample", busy, 1);
      chk("valid_hold_s", data_valid, pv);
      chk("overrun_s", overrun, 0);
      swchk(code, 0, 1'b0);
      negchk(1'b0);
      tick();
    end
    for (int j = 0; j < k; j++) begin
      sample_len    = SW'(l);
      en_offset_cal = ~cal;  // latched value must hold
      comp_p        = (j < NB) ? code[NB-1-j] : 1'($urandom);
      start         = (j == start_at);
      data_ready    = (j == k - 1) ? ready_last : 1'b0;
      chk("sample_o_conv", sample_o, 0);
      chk("busy_conv", busy, 1);
      chk("offset_cal_cycle", offset_cal_cycle, (j == NB));
      chk("valid_hold_c", data_valid, pv);
      chk("overrun_c", overrun, 0);
      swchk(code, j, 1'b1);
      negchk(1'b1);
      tick();
    end
    start         = 1'b0;
    data_ready    = 1'b0;
    en_offset_cal = 1'b0;
    chk("data_o", data_o, code);
    chk("data_valid", data_valid, 1);
    chk("overrun", overrun, exp_ov);
    chk("next_sample", sample_o, cont);
    chk("next_busy", busy, cont);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sample_o"}, sample_o, 0);
    chk({tag, "_cal"}, offset_cal_cycle, 0);
    chk({tag, "_data_o"}, data_o, 0);
    chk({tag, "_valid"}, data_valid, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_vcm"}, vcm_o, 0);
    chk({tag, "_vref_p"}, vref_z_p_o, 11'h7FF);
    chk({tag, "_vref_n"}, vref_z_n_o, 11'h7FF);
    chk({tag, "_vss_p"}, vss_p_o, 0);
    chk({tag, "_vss_n"}, vss_n_o, 0);
  endtask

  vec_t vecs[6];

  initial begin
    checks        = 0;
    errors        = 0;
    rst_z         = 1'b0;
    start         = 1'b0;
    cont          = 1'b0;
    en_offset_cal = 1'b0;
    sample_len    = '0;
    comp_p        = 1'b0;
    vin_p_sw_on   = 1'b0;
    vin_n_sw_on   = 1'b0;
    data_ready    = 1'b0;

    vecs[0] = '{code: 12'hA5C, l: 1,  cal: 1'b0};
    vecs[1] = '{code: 12'hA5C, l: 1,  cal: 1'b1};
    vecs[2] = '{code: 12'hFFF, l: 0,  cal: 1'b0};
    vecs[3] = '{code: 12'h000, l: 3,  cal: 1'b1};
    vecs[4] = '{code: 12'h001, l: 15, cal: 1'b0};
    vecs[5] = '{code: 12'h800, l: 2,  cal: 1'b1};

    #2;
    reset_vals("rst");
    negchk(1'b0);
    tick();
    rst_z = 1'b1;
    tick();

    // Single-shot table: buffer drained first, so no overrun and valid rises only at the end.
    foreach (vecs[i]) begin
      data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
      launch(vecs[i].l);
      body(vecs[i].code, vecs[i].l, vecs[i].cal, 1'b0, 1'b0, 1'b0, -1);
    end

    // Start pulse mid-CONVERT is ignored; unread result overwritten -> overrun.
    launch(2);
    body(12'h3A6, 2, 1'b0, 1'b0, 1'b1, 1'b1, 3);
    tick();
    chk("ign_start_idle", busy, 0);
    chk("ovr_one_cycle", overrun, 0);

    // Consume and load on the same edge: load wins, no overrun.
    launch(1);
    body(12'h5C3, 1, 1'b1, 1'b1, 1'b1, 1'b0, -1);
    data_ready = 1'b1;
    tick();
    chk("valid_cleared", data_valid, 0);
    data_ready = 1'b0;

    // Input switches still closed: VCM held off during CONVERT.
    vin_p_sw_on = 1'b1;
    launch(0);
    body(12'h6B1, 0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    vin_p_sw_on = 1'b0;
    vin_n_sw_on = 1'b1;
    launch(1);
    body(12'h19E, 1, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    vin_n_sw_on = 1'b0;
    data_ready  = 1'b1;
    tick();
    data_ready  = 1'b0;

    // Continuous: back-to-back results, second overwrites the unread first.
    cont = 1'b1;
    launch(1);
    body(12'h2D4, 1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    cont = 1'b0;
    body(12'hC3B, 1, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    tick();
    chk("cont_ovr_pulse", overrun, 0);
    chk("cont_valid_stays", data_valid, 1);
    chk("cont_idle", busy, 0);

    // Reset in CONVERT cycle 5: outputs revert immediately.
    launch(1);
    tick();
    tick();
    for (int j = 0; j < 5; j++) begin
      comp_p = 1'b1;
      tick();
    end
    chk("pre_rst_busy", busy, 1);
    #2;
    rst_z = 1'b0;
    #1;
    reset_vals("mid_rst");
    negchk(1'b0);
    tick();
    rst_z = 1'b1;
    tick();
    chk("post_rst_idle", busy, 0);
    launch(1);
    body(12'h947, 1, 1'b0, 1'b0, 1'b0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
